// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the MEM-stage SRAM access controller.
package mem_access_ctrl_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, DONE, EXC} state_t;

    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    // SRAM strobes are active low
    localparam logic       STB_ON  = 1'b0;
    localparam logic       STB_OFF = 1'b1;
    localparam logic [3:0] BE_OFF  = 4'hF;

    // Byte address -> word address; callers truncate to the SRAM width
    function automatic logic [29:0] word_addr(input logic [31:0] pa);
        return pa[31:2];
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// MEM-stage, TLB and SRAM signals of the access controller.
interface mem_access_ctrl_if #(parameter int SRAM_AW = 20);
    logic               req_i, we_i, flush_i;
    logic [31:0]        addr_i, wdata_i;
    logic [3:0]         sel_i;
    logic [31:0]        vaddr_o;
    logic               tlb_hit_i;
    logic [31:0]        paddr_i;
    logic [31:0]        rdata_o;
    logic               ack_o, stall_o;
    logic               exc_tlbl_o, exc_tlbs_o, exc_adel_o, exc_ades_o;
    logic [31:0]        badvaddr_o;
    logic [SRAM_AW-1:0] sram_addr_o;
    logic [31:0]        sram_data_o, sram_data_i;
    logic               sram_ce_n_o, sram_oe_n_o, sram_we_n_o;
    logic [3:0]         sram_be_n_o;

    modport slave (
        input  req_i, we_i, addr_i, sel_i, wdata_i, flush_i, tlb_hit_i, paddr_i, sram_data_i,
        output vaddr_o, rdata_o, ack_o, stall_o, exc_tlbl_o, exc_tlbs_o, exc_adel_o,
               exc_ades_o, badvaddr_o, sram_addr_o, sram_data_o, sram_ce_n_o, sram_oe_n_o,
               sram_we_n_o, sram_be_n_o
    );

    modport master (
        output req_i, we_i, addr_i, sel_i, wdata_i, flush_i, tlb_hit_i, paddr_i, sram_data_i,
        input  vaddr_o, rdata_o, ack_o, stall_o, exc_tlbl_o, exc_tlbs_o, exc_adel_o,
               exc_ades_o, badvaddr_o, sram_addr_o, sram_data_o, sram_ce_n_o, sram_oe_n_o,
               sram_we_n_o, sram_be_n_o
    );
endinterface

// File: rtl/mem_access_ctrl_align_check.sv
// Byte-enable / low-address alignment check: word on 4, halfword on 2, byte anywhere.
module mem_access_ctrl_align_check (
    input  logic [3:0] sel,
    input  logic [1:0] addr_lo,
    output logic       misaligned
);
    logic legal;

    always_comb begin
        legal = 1'b0;
        if (sel == 4'b1111 && addr_lo == 2'b00)                  legal = 1'b1;
        if ((sel == 4'b0011 || sel == 4'b1100) && !addr_lo[0])   legal = 1'b1;
        if ($onehot(sel))                                        legal = 1'b1;
        misaligned = ~legal;
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: alignment/TLB exceptions, then a multi-cycle
// asynchronous SRAM cycle while holding the pipeline.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int SRAM_AW     = 20
) (
    input logic              clk,
    input logic              rst,
    mem_access_ctrl_if.slave bus
);
    state_t     state;
    logic [3:0] cnt;
    logic       st_we, ack_sup;
    logic       misaligned, fault, oor, accept;
    logic [4:0] exc_code;
    logic [31:0] rd_mask;

    mem_access_ctrl_align_check u_align (
        .sel        (bus.sel_i),
        .addr_lo    (bus.addr_i[1:0]),
        .misaligned (misaligned)
    );

    assign bus.vaddr_o = bus.addr_i;
    assign bus.stall_o = (state == IDLE && bus.req_i) ||
                         state == SETUP || state == STROBE || state == EXC;

    always_comb begin
        accept   = state == IDLE && bus.req_i && !bus.flush_i;
        fault    = misaligned || !bus.tlb_hit_i;
        // misalignment outranks a TLB miss
        exc_code = misaligned ? (bus.we_i ? EXC_ADES : EXC_ADEL)
                              : (bus.we_i ? EXC_TLBS : EXC_TLBL);
        oor      = (bus.paddr_i >> (SRAM_AW + 2)) != 32'd0;
        rd_mask  = {{8{~bus.sram_be_n_o[3]}}, {8{~bus.sram_be_n_o[2]}},
                    {8{~bus.sram_be_n_o[1]}}, {8{~bus.sram_be_n_o[0]}}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            st_we           <= 1'b0;
            ack_sup         <= 1'b0;
            bus.ack_o       <= 1'b0;
            bus.exc_tlbl_o  <= 1'b0;
            bus.exc_tlbs_o  <= 1'b0;
            bus.exc_adel_o  <= 1'b0;
            bus.exc_ades_o  <= 1'b0;
            bus.rdata_o     <= '0;
            bus.badvaddr_o  <= '0;
            bus.sram_addr_o <= '0;
            bus.sram_data_o <= '0;
            bus.sram_ce_n_o <= STB_OFF;
            bus.sram_oe_n_o <= STB_OFF;
            bus.sram_we_n_o <= STB_OFF;
            bus.sram_be_n_o <= BE_OFF;
        end else begin
            bus.ack_o      <= 1'b0;
            bus.exc_tlbl_o <= 1'b0;
            bus.exc_tlbs_o <= 1'b0;
            bus.exc_adel_o <= 1'b0;
            bus.exc_ades_o <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (fault) begin
                        bus.badvaddr_o <= bus.addr_i;
                        bus.exc_tlbl_o <= exc_code == EXC_TLBL;
                        bus.exc_tlbs_o <= exc_code == EXC_TLBS;
                        bus.exc_adel_o <= exc_code == EXC_ADEL;
                        bus.exc_ades_o <= exc_code == EXC_ADES;
                        state          <= EXC;
                    end else if (oor) begin
                        // unmapped physical space completes silently with zero data
                        bus.rdata_o <= '0;
                        bus.ack_o   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        bus.sram_addr_o <= SRAM_AW'(word_addr(bus.paddr_i));
                        bus.sram_data_o <= bus.wdata_i;
                        bus.sram_be_n_o <= ~bus.sel_i;
                        bus.sram_ce_n_o <= STB_ON;
                        st_we           <= bus.we_i;
                        ack_sup         <= 1'b0;
                        state           <= SETUP;
                    end
                end
                SETUP: begin
                    if (bus.flush_i) begin
                        bus.sram_ce_n_o <= STB_OFF;
                        bus.sram_be_n_o <= BE_OFF;
                        state           <= IDLE;
                    end else begin
                        cnt <= 4'(WAIT_CYCLES - 1);
                        if (st_we) bus.sram_we_n_o <= STB_ON;
                        else       bus.sram_oe_n_o <= STB_ON;
                        state <= STROBE;
                    end
                end
                STROBE: begin
                    if (bus.flush_i && !st_we) begin
                        bus.sram_ce_n_o <= STB_OFF;
                        bus.sram_oe_n_o <= STB_OFF;
                        bus.sram_be_n_o <= BE_OFF;
                        state           <= IDLE;
                    end else begin
                        // a flushed store still finishes its write, only the ack is dropped
                        if (bus.flush_i) ack_sup <= 1'b1;
                        if (cnt == 4'd0) begin
                            if (!st_we) bus.rdata_o <= bus.sram_data_i & rd_mask;
                            bus.ack_o       <= !(ack_sup || bus.flush_i);
                            bus.sram_ce_n_o <= STB_OFF;
                            bus.sram_oe_n_o <= STB_OFF;
                            bus.sram_we_n_o <= STB_OFF;
                            bus.sram_be_n_o <= BE_OFF;
                            state           <= DONE;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                EXC:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: responses are checked through a scoreboard queue.
module tb_mem_access_ctrl;
    localparam int WAIT_CYCLES = 2;
    localparam int SRAM_AW     = 20;
    localparam int K_ACK = 0, K_TLBL = 1, K_TLBS = 2, K_ADEL = 3, K_ADES = 4;

    typedef struct {
        int          kind;
        logic        ld;
        logic [31:0] rd;
        logic [31:0] bad;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   fails  = 0;
    exp_t sbq[$];

    mem_access_ctrl_if #(.SRAM_AW(SRAM_AW)) bus ();

    mem_access_ctrl #(.WAIT_CYCLES(WAIT_CYCLES), .SRAM_AW(SRAM_AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every ack/exception pulse consumes one scoreboard entry
    always @(negedge clk) begin
        int   k;
        exp_t e;
        if (!rst && (bus.ack_o || bus.exc_tlbl_o || bus.exc_tlbs_o ||
                     bus.exc_adel_o || bus.exc_ades_o)) begin
            k = bus.ack_o ? K_ACK : bus.exc_tlbl_o ? K_TLBL : bus.exc_tlbs_o ? K_TLBS :
                bus.exc_adel_o ? K_ADEL : K_ADES;
            if (sbq.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_resp: got kind %0d expected none", k);
            end else begin
                e = sbq.pop_front();
                chk("resp_kind", 32'(k), 32'(e.kind));
                chk("one_pulse", 32'($countones({bus.ack_o, bus.exc_tlbl_o, bus.exc_tlbs_o,
                                                 bus.exc_adel_o, bus.exc_ades_o})), 32'd1);
                if (e.kind == K_ACK && e.ld) chk("rdata", bus.rdata_o, e.rd);
                if (e.kind != K_ACK)         chk("badvaddr", bus.badvaddr_o, e.bad);
            end
        end
    end

    task automatic drive_req(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                             input logic [31:0] wd, input logic hit, input logic [31:0] pa,
                             input logic [31:0] sd);
        bus.req_i = 1'b1;  bus.we_i = we;   bus.addr_i = addr; bus.sel_i = sel;
        bus.wdata_i = wd;  bus.tlb_hit_i = hit; bus.paddr_i = pa; bus.sram_data_i = sd;
    endtask

    // Later inputs are scrambled so only latched request values can matter
    task automatic scramble();
        bus.req_i = 1'b0;  bus.we_i = ~bus.we_i; bus.addr_i = 32'h5555_5555;
        bus.sel_i = 4'b0000; bus.wdata_i = 32'h0; bus.tlb_hit_i = 1'b0;
        bus.paddr_i = 32'hFFFF_FFFF;
    endtask

    task automatic access(input string nm, input logic we, input logic [31:0] addr,
                          input logic [3:0] sel, input logic [31:0] wd, input logic hit,
                          input logic [31:0] pa, input logic [31:0] sd, input int kind,
                          input logic [31:0] exp_rd, input int exp_lat, input int exp_oe,
                          input int exp_we, input logic [3:0] exp_be, input logic [19:0] exp_sa);
        int oe = 0, wn = 0, lat = -1, st_low = 0;
        logic [3:0]  be_seen = 4'hF;
        logic [19:0] sa = '0;
        logic [31:0] sdat = '0;
        @(negedge clk);
        sbq.push_back('{kind: kind, ld: !we, rd: exp_rd, bad: addr});
        drive_req(we, addr, sel, wd, hit, pa, sd);
        #1 chk({nm, "_stall_req"}, 32'(bus.stall_o), 32'd1);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) begin
                scramble();
                be_seen = bus.sram_be_n_o; sa = bus.sram_addr_o; sdat = bus.sram_data_o;
            end
            if (!bus.sram_oe_n_o) oe++;
            if (!bus.sram_we_n_o) wn++;
            if (bus.ack_o || bus.exc_tlbl_o || bus.exc_tlbs_o || bus.exc_adel_o ||
                bus.exc_ades_o) begin
                lat = c;
                chk({nm, "_stall_end"}, 32'(bus.stall_o), 32'(kind != K_ACK));
                break;
            end
            if (!bus.stall_o) st_low++;
        end
        chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, "_oe_cycles"}, 32'(oe), 32'(exp_oe));
        chk({nm, "_we_cycles"}, 32'(wn), 32'(exp_we));
        chk({nm, "_be_n"}, 32'(be_seen), 32'(exp_be));
        chk({nm, "_stall_hold"}, 32'(st_low), 32'd0);
        if (exp_oe + exp_we > 0) chk({nm, "_sram_addr"}, 32'(sa), 32'(exp_sa));
        if (exp_we > 0)          chk({nm, "_sram_data"}, sdat, wd);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ack_seen, wn;
        bus.req_i = 0; bus.we_i = 0; bus.addr_i = 0; bus.sel_i = 0; bus.wdata_i = 0;
        bus.flush_i = 0; bus.tlb_hit_i = 1; bus.paddr_i = 0; bus.sram_data_i = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_strobes", {27'd0, bus.sram_ce_n_o, bus.sram_oe_n_o, bus.sram_we_n_o,
                              bus.sram_be_n_o == 4'hF, bus.stall_o}, 32'h1E);
        chk("reset_pulses", 32'({bus.ack_o, bus.exc_tlbl_o, bus.exc_tlbs_o, bus.exc_adel_o,
                                 bus.exc_ades_o}), 32'd0);
        chk("reset_regs", bus.rdata_o | bus.badvaddr_o | bus.sram_data_o |
                          32'(bus.sram_addr_o), 32'd0);

        //      name    we  addr          sel      wdata         hit pa            sram_data     kind    rdata         lat oe we be_n     sram_addr
        access("ld_w",  0, 32'h8000_1000, 4'b1111, 32'h0,        1, 32'h0000_1000, 32'hDEADBEEF, K_ACK,  32'hDEADBEEF, 4, 2, 0, 4'b0000, 20'h00400);
        access("st_b",  1, 32'h8000_0003, 4'b1000, 32'hAB00_0000, 1, 32'h0000_0003, 32'h0,        K_ACK,  32'h0,        4, 0, 2, 4'b0111, 20'h00000);
        access("ades",  1, 32'h8000_0002, 4'b1111, 32'h1234_5678, 1, 32'h0000_0002, 32'h0,        K_ADES, 32'h0,        1, 0, 0, 4'b1111, 20'h0);
        access("tlbl",  0, 32'h0040_0000, 4'b1111, 32'h0,        0, 32'h0,         32'h0,        K_TLBL, 32'h0,        1, 0, 0, 4'b1111, 20'h0);
        access("tlbs",  1, 32'h0040_0000, 4'b1111, 32'h0,        0, 32'h0,         32'h0,        K_TLBS, 32'h0,        1, 0, 0, 4'b1111, 20'h0);
        access("ld_h",  0, 32'h8000_0102, 4'b0011, 32'h0,        1, 32'h0000_0102, 32'hDEADBEEF, K_ACK,  32'h0000BEEF, 4, 2, 0, 4'b1100, 20'h00040);
        access("adel_h",0, 32'h8000_0001, 4'b1100, 32'h0,        0, 32'h0,         32'h0,        K_ADEL, 32'h0,        1, 0, 0, 4'b1111, 20'h0);
        access("adel_s",0, 32'h8000_0000, 4'b0110, 32'h0,        1, 32'h0,         32'h0,        K_ADEL, 32'h0,        1, 0, 0, 4'b1111, 20'h0);
        access("oor",   0, 32'h8040_0000, 4'b1111, 32'h0,        1, 32'h0040_0000, 32'hDEADBEEF, K_ACK,  32'h0,        1, 0, 0, 4'b1111, 20'h0);
        access("top",   0, 32'h803F_FFFC, 4'b1111, 32'h0,        1, 32'h003F_FFFC, 32'h1234_5678, K_ACK, 32'h1234_5678, 4, 2, 0, 4'b0000, 20'hFFFFF);
        access("ld_b",  0, 32'h8000_0005, 4'b0100, 32'h0,        1, 32'h0000_0005, 32'hA5C3_E781, K_ACK, 32'h00C3_0000, 4, 2, 0, 4'b1011, 20'h00001);

        // Flush in the first STROBE cycle of a load: abort, no ack
        @(negedge clk);
        drive_req(0, 32'h8000_2000, 4'b1111, 32'h0, 1, 32'h0000_2000, 32'hCAFE_F00D);
        @(negedge clk); scramble();
        @(negedge clk);
        chk("fl_ld_oe_low", 32'(bus.sram_oe_n_o), 32'd0);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        chk("fl_ld_strobes", 32'({bus.sram_ce_n_o, bus.sram_oe_n_o, bus.stall_o}), 32'b110);
        ack_seen = 0;
        repeat (4) begin @(negedge clk); if (bus.ack_o) ack_seen++; end
        chk("fl_ld_no_ack", 32'(ack_seen), 32'd0);
        access("after_fl", 0, 32'h8000_2000, 4'b1111, 32'h0, 1, 32'h0000_2000, 32'hCAFE_F00D,
               K_ACK, 32'hCAFE_F00D, 4, 2, 0, 4'b0000, 20'h00800);

        // Flush during a store's STROBE: write completes, ack dropped
        @(negedge clk);
        drive_req(1, 32'h8000_0010, 4'b1111, 32'h0BAD_CAFE, 1, 32'h0000_0010, 32'h0);
        wn = 0; ack_seen = 0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) scramble();
            bus.flush_i = (c == 2);
            if (!bus.sram_we_n_o) wn++;
            if (bus.ack_o) ack_seen++;
        end
        bus.flush_i = 1'b0;
        chk("fl_st_we_cycles", 32'(wn), 32'(WAIT_CYCLES));
        chk("fl_st_no_ack", 32'(ack_seen), 32'd0);

        // Reset in STROBE of a store
        @(negedge clk);
        drive_req(1, 32'h8000_0020, 4'b0001, 32'h0000_00AA, 1, 32'h0000_0020, 32'h0);
        @(negedge clk); scramble();
        @(negedge clk);
        chk("rst_st_we_low", 32'(bus.sram_we_n_o), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_st_strobes", {26'd0, bus.sram_ce_n_o, bus.sram_oe_n_o, bus.sram_we_n_o,
                               bus.sram_be_n_o == 4'hF, bus.stall_o, bus.ack_o}, 32'b111100);
        chk("rst_st_state", 32'(dut.state), 32'd0);
        access("after_rst", 0, 32'h8000_0004, 4'b1111, 32'h0, 1, 32'h0000_0004, 32'h0102_0304,
               K_ACK, 32'h0102_0304, 4, 2, 0, 4'b0000, 20'h00001);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
